// File: rtl/my_pipe_pkg.sv
// Shared constants for the my_pipe arithmetic pipeline.
// The optional valid-tracking path is enabled with MY_PIPE_VALID_EN.
package my_pipe_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int PIPE_LATENCY  = 3;

endpackage

// File: rtl/my_pipe_stage_reg.sv
// One pipeline register: W bits, synchronous active-high clear.
module my_pipe_stage_reg
    import my_pipe_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/my_pipe.sv
// Three-stage pipeline computing F = ((A + B) + (C - D)) * D, all modulo 2^N.
// Define MY_PIPE_VALID_EN to add in_valid/out_valid tracking alongside the data.
module my_pipe
    import my_pipe_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    output logic [N-1:0] F,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic         clk,
    input  logic         rst
`ifdef MY_PIPE_VALID_EN
    ,
    input  logic         in_valid,
    output logic         out_valid
`endif
);

    logic [N-1:0] w_s1_sum_d;
    logic [N-1:0] w_s1_diff_d;
    logic [N-1:0] w_s1_sum;
    logic [N-1:0] w_s1_diff;
    logic [N-1:0] w_s1_d;
    logic [N-1:0] w_s2_sum_d;
    logic [N-1:0] w_s2_sum;
    logic [N-1:0] w_s2_d;
    logic [N-1:0] w_prod;

    // Every result is N bits wide, so carries and the upper product half drop off.
    assign w_s1_sum_d  = A + B;
    assign w_s1_diff_d = C - D;
    assign w_s2_sum_d  = w_s1_sum + w_s1_diff;
    assign w_prod      = w_s2_sum * w_s2_d;

    my_pipe_stage_reg #(.W(N)) u_s1_sum (
        .clk (clk),
        .rst (rst),
        .i_d (w_s1_sum_d),
        .o_q (w_s1_sum)
    );

    my_pipe_stage_reg #(.W(N)) u_s1_diff (
        .clk (clk),
        .rst (rst),
        .i_d (w_s1_diff_d),
        .o_q (w_s1_diff)
    );

    // D travels with its operand set so stage 3 multiplies by the matching D.
    my_pipe_stage_reg #(.W(N)) u_s1_d (
        .clk (clk),
        .rst (rst),
        .i_d (D),
        .o_q (w_s1_d)
    );

    my_pipe_stage_reg #(.W(N)) u_s2_sum (
        .clk (clk),
        .rst (rst),
        .i_d (w_s2_sum_d),
        .o_q (w_s2_sum)
    );

    my_pipe_stage_reg #(.W(N)) u_s2_d (
        .clk (clk),
        .rst (rst),
        .i_d (w_s1_d),
        .o_q (w_s2_d)
    );

    my_pipe_stage_reg #(.W(N)) u_s3_f (
        .clk (clk),
        .rst (rst),
        .i_d (w_prod),
        .o_q (F)
    );

`ifdef MY_PIPE_VALID_EN
    // Valid is only a tag; the data registers above update every cycle regardless.
    logic [PIPE_LATENCY-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[PIPE_LATENCY-2:0], in_valid};
        end
    end

    assign out_valid = r_valid[PIPE_LATENCY-1];
`endif

endmodule

// File: tb/tb_my_pipe.sv
// Self-checking bench for my_pipe: expected F values are queued when operands are
// driven and popped one per clock edge; out_valid is checked when MY_PIPE_VALID_EN is set.
module tb_my_pipe;

    localparam int N = 10;

    logic         clk;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic [N-1:0] D;
    logic [N-1:0] F;
`ifdef MY_PIPE_VALID_EN
    logic         in_valid;
    logic         out_valid;
    logic         vexp_q[$];
`endif

    logic [N-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    my_pipe #(.N(N)) dut (
        .F   (F),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .clk (clk),
        .rst (rst)
`ifdef MY_PIPE_VALID_EN
        ,
        .in_valid  (in_valid),
        .out_valid (out_valid)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] c, input logic [N-1:0] d);
        logic [N-1:0] sum;
        logic [N-1:0] diff;
        logic [N-1:0] prod;
        sum  = a + b;
        diff = c - d;
        sum  = sum + diff;
        prod = sum * d;
        return prod;
    endfunction

    // ---------------- driver ----------------
    // Applies one operand set for one rising edge and queues what F must show
    // two edges later. A reset edge flushes the queue: F is 0 on that edge and the next two.
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic [N-1:0] d,
                         input logic r, input logic v, input logic [N-1:0] e);
        A   = a;
        B   = b;
        C   = c;
        D   = d;
        rst = r;
`ifdef MY_PIPE_VALID_EN
        in_valid = v;
        if (r) begin
            vexp_q.delete();
            repeat (3) vexp_q.push_back(1'b0);
        end else begin
            vexp_q.push_back(v);
        end
`else
        if (v) begin end
`endif
        if (r) begin
            exp_q.delete();
            repeat (3) exp_q.push_back('0);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [N-1:0] got;
        logic [N-1:0] exp;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0, 1: drive(N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)),
                            N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)),
                            1'b1, 1'b1, '0);
                2:    drive(10, 12, 6, 3, 1'b0, 1'b1, 75);
                default: drive(0, 0, 0, 0, 1'b0, 1'b0, 0);
            endcase
            got = F;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d]: F=%0d expected %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] tbl[9][5];
        logic [N-1:0] got;
        logic [N-1:0] exp;
        tbl = '{'{10, 10, 5, 3, 66}, '{20, 11, 1, 4, 112}, '{15, 10, 8, 2, 62},
                '{8, 15, 5, 0, 0},   '{10, 20, 5, 3, 96},  '{10, 10, 30, 1, 49},
                '{30, 1, 2, 4, 116}, '{0, 0, 0, 0, 0},     '{0, 0, 0, 0, 0}};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 1'b0, 1'b1, tbl[i][4]);
            got = F;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: F=%0d expected %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_d_alignment();
        logic [N-1:0] dv[5];
        logic [N-1:0] ev[5];
        logic [N-1:0] got;
        logic [N-1:0] exp;
        dv = '{1, 2, 3, 3, 3};
        ev = '{2, 2, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, dv[i], 1'b0, 1'b1, ev[i]);
            got = F;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL d_alignment[%0d]: F=%0d expected %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] tbl[4][5];
        logic [N-1:0] got;
        logic [N-1:0] exp;
        tbl = '{'{1023, 1023, 1023, 0, 0}, '{500, 500, 100, 2, 148},
                '{1023, 1023, 0, 1023, 1}, '{0, 0, 0, 0, 0}};
        // Third row: 2046->1022, 0-1023->1, 1022+1=1023, 1023*1023 mod 1024 = 1.
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 1'b0, 1'b1, tbl[i][4]);
            got = F;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL overflow[%0d]: F=%0d expected %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, c, d;
        logic [N-1:0] got;
        logic [N-1:0] exp;
        for (int i = 0; i < 30; i++) begin
            a = N'($urandom_range(0, 1023));
            b = N'($urandom_range(0, 1023));
            c = N'($urandom_range(0, 1023));
            d = N'($urandom_range(0, 1023));
            drive(a, b, c, d, 1'b0, 1'b1, model(a, b, c, d));
            got = F;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: F=%0d expected %0d", i, got, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] tbl[9][6];
        logic [N-1:0] got;
        logic [N-1:0] exp;
        // Columns: A, B, C, D, rst, expected F for this set.
        tbl = '{'{10, 10, 5, 3, 0, 66}, '{20, 11, 1, 4, 0, 112}, '{15, 10, 8, 2, 0, 62},
                '{30, 1, 2, 4, 1, 0},   '{10, 12, 6, 3, 0, 75},  '{10, 10, 30, 1, 0, 49},
                '{1, 1, 1, 2, 0, 2},    '{0, 0, 0, 0, 0, 0},     '{0, 0, 0, 0, 0, 0}};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4][0], 1'b1, tbl[i][5]);
            got = F;
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: F=%0d expected %0d", i, got, exp);
            end
        end
    endtask

`ifdef MY_PIPE_VALID_EN
    task automatic test_valid();
        logic vpat[9];
        logic rpat[9];
        logic got_v;
        logic exp_v;
        logic [N-1:0] got;
        logic [N-1:0] exp;
        vpat = '{0, 1, 0, 1, 1, 0, 0, 1, 1};
        rpat = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin
            drive(3, 4, 5, 2, rpat[i], vpat[i], model(3, 4, 5, 2));
            got   = F;
            exp   = exp_q.pop_front();
            got_v = out_valid;
            exp_v = vexp_q.pop_front();
            n_checks += 2;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL valid_data[%0d]: F=%0d expected %0d", i, got, exp);
            end
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL valid_flag[%0d]: out_valid=%0b expected %0b", i, got_v, exp_v);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        A   = '0;
        B   = '0;
        C   = '0;
        D   = '0;
`ifdef MY_PIPE_VALID_EN
        in_valid = 1'b0;
`endif
        test_reset();
        test_back_to_back();
        test_d_alignment();
        test_overflow();
        test_random();
        test_mid_reset();
`ifdef MY_PIPE_VALID_EN
        test_valid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
